// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that shares one sel/wr/addr/wdata/rdata/ready register bus
// between NUM_REQ requesters, with a per-access timeout and a one-hot response.
module reg_bus_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_accept,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           sel,
    output logic                           wr,
    output logic [ADDR_WIDTH-1:0]          addr,
    output logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH-1:0]          rdata,
    input  logic                           ready
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0]      LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic [GW-1:0]         w_pick;
    logic                  w_found;
    logic [CW-1:0]         r_cnt;
    logic                  w_timeout;
    logic                  r_sel;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    // Scan starts just after the last winner, so a held request waits at most NUM_REQ-1 grants.
    always_comb begin : p_arb
        int idx;
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = GW'(idx);
            end
        end
    end

    assign w_timeout = (r_cnt == CNT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_next = ACCESS;
            ACCESS:  if (ready || w_timeout) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= LAST_INIT;
            r_cnt        <= '0;
            r_sel        <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant      <= w_pick;
                        r_last_grant <= w_pick;
                        r_cnt        <= '0;
                        r_sel        <= 1'b1;
                        r_wr         <= req_wr[w_pick];
                        r_addr       <= req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata      <= req_wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ACCESS: begin
                    if (ready) begin
                        r_rsp_rdata <= r_wr ? '0 : rdata;
                        r_rsp_err   <= 1'b0;
                        r_sel       <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_sel       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_wr    <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end
                default: ;
            endcase
        end
    end

    // Accept is gated by rst so a pending request cannot pulse it while reset is held.
    assign req_accept = (r_state == IDLE && w_found && !rst) ? (ONE_HOT0 << w_pick) : '0;
    assign rsp_valid  = (r_state == RESP) ? (ONE_HOT0 << r_grant) : '0;
    assign rsp_err    = (r_state == RESP) && r_rsp_err;
    assign rsp_rdata  = r_rsp_rdata;
    assign sel        = r_sel;
    assign wr         = r_wr;
    assign addr       = r_addr;
    assign wdata      = r_wdata;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: a combinational-ready memory slave and
// hand-computed expectations for write, read-back, contention, timeout, reset and stray ready.
module tb_reg_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_wr;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_accept;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              sel;
    logic              wr;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    logic [DW-1:0]     rdata;
    logic              ready;

    logic              slave_en;
    logic              stray_ready;
    logic [DW-1:0]     mem [0:255];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_fall = -1;

    logic          exp_w [NR];
    logic [AW-1:0] exp_a [NR];
    logic [DW-1:0] exp_d [NR];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave answers in the same cycle sel is seen; stray_ready drives ready when the slave is off.
    assign ready = slave_en ? sel : stray_ready;
    assign rdata = mem[addr];
    always @(posedge clk) if (sel && ready && wr) mem[addr] <= wdata;

    reg_bus_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sel(sel), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[id]           = 1'b1;
        req_wr[id]              = w;
        req_addr[id*AW +: AW]   = a;
        req_wdata[id*DW +: DW]  = d;
        exp_w[id] = w;
        exp_a[id] = a;
        exp_d[id] = d;
    endtask

    // Waits (bounded) for the grant to id, then checks the bus phase, its length and the response.
    task automatic serve(input int id, input logic [DW-1:0] exp_rd, input logic exp_err,
                         input int exp_len, input bit chk_gap);
        int n;
        int rise;
        n = 0;
        #1;
        while (req_accept == '0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check($sformatf("accept_r%0d", id), req_accept, 32'd1 << id);
        @(negedge clk);
        req_valid[id] = 1'b0;
        #1;
        rise = cyc;
        check("sel_on", sel, 1);
        check("bus_wr", wr, exp_w[id]);
        check("bus_addr", addr, exp_a[id]);
        check("bus_wdata", wdata, exp_d[id]);
        if (chk_gap) check("idle_gap", rise - last_fall, 2);
        n = 0;
        while (sel === 1'b1 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        last_fall = cyc;
        check("sel_len", n, exp_len);
        check($sformatf("rsp_valid_r%0d", id), rsp_valid, 32'd1 << id);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        @(negedge clk); #1;
        check("rsp_pulse_end", rsp_valid, 0);
        check("rsp_err_idle", rsp_err, 0);
        check("idle_addr", addr, 0);
        check("idle_wr", wr, 0);
        check("idle_wdata", wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = '0;
        req_wr      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        slave_en    = 1'b1;
        stray_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_sel", sel, 0);
        check("rst_wr", wr, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_accept", req_accept, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;

        // Write then read-back through a different requester.
        set_req(0, 1'b1, 8'haa, 16'he513);
        serve(0, 16'h0000, 1'b0, 1, 1'b0);
        set_req(2, 1'b0, 8'haa, 16'h0000);
        serve(2, 16'he513, 1'b0, 1, 1'b1);

        // Contention after reset: all four held, then 0 and 3.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        set_req(0, 1'b1, 8'h20, 16'h1111);
        set_req(1, 1'b1, 8'h21, 16'h2222);
        set_req(2, 1'b0, 8'h20, 16'h0000);
        set_req(3, 1'b0, 8'h21, 16'h0000);
        serve(0, 16'h0000, 1'b0, 1, 1'b0);
        serve(1, 16'h0000, 1'b0, 1, 1'b1);
        serve(2, 16'h1111, 1'b0, 1, 1'b1);
        serve(3, 16'h2222, 1'b0, 1, 1'b1);
        set_req(0, 1'b1, 8'h30, 16'h3333);
        set_req(3, 1'b0, 8'h30, 16'h0000);
        serve(0, 16'h0000, 1'b0, 1, 1'b1);
        serve(3, 16'h3333, 1'b0, 1, 1'b1);

        // Timeout on a read, then a normal access.
        slave_en = 1'b0;
        set_req(1, 1'b0, 8'h10, 16'h0000);
        serve(1, 16'h0000, 1'b1, TO, 1'b1);
        slave_en = 1'b1;
        set_req(2, 1'b0, 8'h20, 16'h0000);
        serve(2, 16'h1111, 1'b0, 1, 1'b1);

        // Reset in the middle of an access; pointer must restart at requester 0.
        slave_en = 1'b0;
        set_req(1, 1'b0, 8'h44, 16'h0000);
        #1;
        check("mid_accept", req_accept, 4'b0010);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_sel_before", sel, 1);
        set_req(0, 1'b1, 8'h50, 16'h5a5a);
        set_req(3, 1'b0, 8'h50, 16'h0000);
        rst = 1'b1;
        #1;
        check("mid_rst_sel", sel, 0);
        check("mid_rst_accept", req_accept, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        check("mid_rst_rsp_hold", rsp_valid, 0);
        rst = 1'b0;
        slave_en = 1'b1;
        serve(0, 16'h0000, 1'b0, 1, 1'b0);
        serve(3, 16'h5a5a, 1'b0, 1, 1'b1);
        set_req(3, 1'b0, 8'haa, 16'h0000);
        serve(3, 16'he513, 1'b0, 1, 1'b1);

        // Stray ready while idle must not move the FSM.
        slave_en    = 1'b0;
        stray_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            check("stray_rsp_valid", rsp_valid, 0);
            check("stray_sel", sel, 0);
        end
        stray_ready = 1'b0;
        slave_en    = 1'b1;
        set_req(1, 1'b0, 8'h21, 16'h0000);
        serve(1, 16'h2222, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
